// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input-ordering path.
// Holds the sample width, the pairer state encoding and a generic bit-reverse.
package fft_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int SAMPLE_W   = 2 * WORD_SIZE;
  localparam int BITREV_MAX = 32;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                   input int w);
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev.sv
// Combinational bit-reverser of parameterised width; zero latency, no flow control.
module fft_bitrev
  import fft_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] in_bits,
  output logic [W-1:0] out_bits
);

  assign out_bits = W'(bitrev(BITREV_MAX'(in_bits), W));

endmodule

// File: rtl/fft_sample_pairer.sv
// Buffers one N-point frame of serial samples, then emits N/2 bit-reverse-ordered pairs
// on consecutive enabled cycles; in_ready is low while draining, en low freezes everything.
module fft_sample_pairer
  import fft_pkg::*;
#(
  parameter int N             = 32,
  parameter int word_size     = WORD_SIZE,
  parameter int address_width = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [2*word_size-1:0]     in_sample,
  output logic                       in_ready,
  output logic [2*word_size-1:0]     sample1,
  output logic [2*word_size-1:0]     sample2,
  output logic                       out_valid,
  output logic                       out_first,
  output logic                       out_last,
  output logic [address_width-2:0]   out_pair
);

  localparam int                      PW        = address_width - 1;
  localparam logic [address_width-1:0] LAST_CNT  = address_width'(N - 1);
  localparam logic [PW-1:0]            LAST_PAIR = PW'(N / 2 - 1);

  state_t                   state, state_nxt;
  logic [address_width-1:0] cnt;
  logic [PW-1:0]            pidx;
  logic [PW-1:0]            pidx_br;
  logic [2*word_size-1:0]   sample_buf [N];
  logic                     accept;

  assign accept = en & in_valid & in_ready;

  fft_bitrev #(.W(PW)) u_bitrev (
    .in_bits  (pidx),
    .out_bits (pidx_br)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   state <= LOAD;
    else if (en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:  if (accept && cnt == LAST_CNT) state_nxt = DRAIN;
      DRAIN: if (pidx == LAST_PAIR)         state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready = (state == LOAD);
  end

  // cnt wraps to zero naturally after the last sample since N is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      pidx <= '0;
    end else if (en) begin
      if (accept) cnt <= cnt + address_width'(1);
      if (state == DRAIN) pidx <= pidx + PW'(1);
      else                pidx <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) sample_buf[cnt] <= in_sample;
  end

  // The second sample of each pair sits exactly half a frame above the first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample1   <= '0;
      sample2   <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_pair  <= '0;
    end else if (en) begin
      if (state == DRAIN) begin
        sample1   <= sample_buf[{1'b0, pidx_br}];
        sample2   <= sample_buf[{1'b1, pidx_br}];
        out_valid <= 1'b1;
        out_first <= (pidx == '0);
        out_last  <= (pidx == LAST_PAIR);
        out_pair  <= pidx;
      end else begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fft_sample_pairer.md
Name: fft_sample_pairer

Overview:
- Input-ordering stage directly upstream of the first-butterfly stage (fftInput).
- Collects one N-point frame of serial complex samples into an internal buffer.
- Then streams N/2 sample pairs on consecutive cycles, in the order the radix-2 DIT first stage needs so that its results land in bit-reversed memory order.
- Its outputs drive fftInput's sample1, sample2 and in_valid inputs directly.

Parameters:
- N, 32, FFT length in points; power of two, N >= 4.
- word_size, 16, bits per real or imaginary component.
- address_width, $clog2(N), index width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  global advance enable; the same net also drives the downstream stage's en.
- in_valid  input  1  serial sample valid.
- in_sample  input  2*word_size  {real[2w-1:w], imag[w-1:0]}.
- in_ready  output  1  block can accept a sample; combinational, equal to (state==LOAD).
- sample1  output  2*word_size  first sample of the current pair (registered).
- sample2  output  2*word_size  second sample of the current pair (registered).
- out_valid  output  1  sample1 and sample2 hold a valid pair (registered).
- out_first  output  1  high with pair 0 of a frame.
- out_last  output  1  high with pair N/2-1 of a frame.
- out_pair  output  address_width-1  index p of the pair currently presented.

Behaviour:
- Buffer: N x 2*word_size register array. It is not reset.
- Counters: load counter cnt (address_width bits) and pair counter pidx (address_width-1 bits).
- States: LOAD and DRAIN.
- Reset values:
  - state=LOAD, cnt=0, pidx=0.
  - sample1=0, sample2=0.
  - out_valid=0, out_first=0, out_last=0, out_pair=0.
- en low: every register holds its value (state, counters, buffer, outputs), and nothing is accepted.
- LOAD:
  - Accept when in_valid & in_ready & en. An accept writes buf[cnt] <= in_sample and increments cnt.
  - out_valid, out_first and out_last are cleared on each enabled edge.
  - An accept with cnt==N-1 moves the block to DRAIN with pidx=0 and cnt=0 (wrap).
  - in_valid while in_ready is low is ignored. No sample is lost, because the source must hold the sample until in_ready.
- DRAIN: on each enabled edge:
  - sample1 <= buf[br(pidx)].
  - sample2 <= buf[br(pidx)+N/2].
  - br() = bit-reverse over address_width-1 bits.
  - out_valid <= 1, out_pair <= pidx.
  - out_first <= (pidx==0), out_last <= (pidx==N/2-1).
  - pidx increments. If pidx==N/2-1, the block returns to LOAD.
- Latency and throughput:
  - Pair 0 is visible the cycle after the first enabled edge that follows the edge accepting the last sample.
  - Pairs are presented on N/2 consecutive enabled cycles with no gaps.
- Frame overlap: none. in_ready is low for exactly N/2 enabled cycles per frame, and the next frame may start on the cycle pair N/2-1 is presented.
- Read/write hazard: none. Buffer writes only occur in LOAD, after the last read.
- Reset mid-operation: a partial frame or drain is discarded immediately; the block resumes in LOAD with cnt=0.
- Arithmetic: no arithmetic on the data; samples pass through bit-exact.

Decomposition:
- fft_pkg holds:
  - the sample width macro/constant (2*word_size);
  - the state encoding (LOAD=1'b0, DRAIN=1'b1);
  - a bit-reverse function parameterised by width.
- One natural sub-module: fft_bitrev, a combinational bit-reverser of parameterised width, instantiated once for pidx.

Test Plan:
- Basic frame, N=8, en=1: feed x[k]={k,16'h100+k}, k=0..7, one per cycle. Required pairs in order:
  - (x0,x4) with out_first=1
  - (x2,x6)
  - (x1,x5)
  - (x3,x7) with out_last=1
  - out_pair sequence 0,2,1,3 is wrong; it must read 0,1,2,3.
- Back-to-back frames, N=8: source holds in_valid=1 continuously.
  - in_ready must be low for exactly 4 cycles per frame.
  - The second frame's 8 samples must produce the correct pairs with no sample dropped or duplicated.
- Gappy input: in_valid toggles 1,0,1,0,... Only asserted samples are stored, and the pair order is unchanged.
- en stall: drop en for 3 cycles mid-drain at pidx=2. Outputs hold for those cycles, then the remaining pairs (x1,x5) and (x3,x7) follow. cnt and state must not advance during the stall.
- Reset mid-load: after 5 samples, pulse reset. All outputs go to 0 and in_ready=1. A fresh 8-sample frame then yields the correct pairs.
- Reset mid-drain: reset after pair 1. out_valid must drop within the same cycle (asynchronous), and no further pairs are emitted until a new full frame is loaded.
